// File: rtl/screen_buffer_pkg.sv
// Shared constants and FSM state type for the double-buffered 160x144 2bpp frame store.
package screen_buffer_pkg;

  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 144;
  localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;
  localparam int SB_ADDR_W     = 15;

  typedef enum logic [1:0] {
    SB_IDLE       = 2'd0,
    SB_WAIT_FRAME = 2'd1,
    SB_CLEAR      = 2'd2,
    SB_ACK        = 2'd3
  } sb_state_t;

endpackage

// File: rtl/screen_buffer_ram.sv
// Two-bank pixel store: one synchronous write port and one registered read port.
module screen_buffer_ram
  import screen_buffer_pkg::*;
#(
  parameter int PIXELS = SCREEN_PIXELS,
  parameter int AW     = SB_ADDR_W
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic [AW:0] i_waddr,
  input  logic [1:0]  i_wdata,
  input  logic        i_re,
  input  logic [AW:0] i_raddr,
  output logic [1:0]  o_rdata
);

  localparam int DEPTH = 2 * PIXELS;
  localparam int IW    = $clog2(DEPTH);

  logic [1:0] r_mem [0:DEPTH-1];
  logic [1:0] r_rdata;

  // Banks are packed back to back so the array holds exactly two frames.
  function automatic logic [IW-1:0] phys(input logic [AW:0] a);
    if (a[AW])
      return IW'(a[AW-1:0]) + IW'(PIXELS);
    return IW'(a[AW-1:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[phys(i_waddr)] <= i_wdata;
    if (i_re)
      r_rdata <= r_mem[phys(i_raddr)];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/screen_buffer.sv
// Double-buffered frame store: renderer writes the back bank, display reads the front bank,
// and the bank swap is tied to the display frame boundary with an optional back-bank clear.
module screen_buffer
  import screen_buffer_pkg::*;
#(
  parameter int         WIDTH         = SCREEN_W,
  parameter int         HEIGHT        = SCREEN_H,
  parameter bit         CLEAR_ON_SWAP = 1'b1,
  parameter logic [1:0] CLEAR_COLOR   = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [1:0] color_in,
  input  logic       swapBuffer,
  output logic       bufferSwapped,
  input  logic       frame_start,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic [1:0] rd_color,
  output logic       rd_valid,
  output logic       front_sel,
  output logic       clearing
);

  localparam int                   PIXELS    = WIDTH * HEIGHT;
  localparam logic [SB_ADDR_W-1:0] W_MUL     = SB_ADDR_W'(WIDTH);
  localparam logic [SB_ADDR_W-1:0] LAST_ADDR = SB_ADDR_W'(PIXELS - 1);
  localparam logic [8:0]           W_LIM     = 9'(WIDTH);
  localparam logic [8:0]           H_LIM     = 9'(HEIGHT);

  function automatic logic [SB_ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    logic [SB_ADDR_W-1:0] yy;
    logic [SB_ADDR_W-1:0] xx;
    yy = SB_ADDR_W'(y);
    xx = SB_ADDR_W'(x);
    if (WIDTH == 160)
      return (yy << 7) + (yy << 5) + xx;
    return yy * W_MUL + xx;
  endfunction

  function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
    return ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  endfunction

  sb_state_t            r_state;
  logic                 r_front_sel;
  logic [SB_ADDR_W-1:0] r_clr_cnt;
  logic                 r_rd_vld_p1;
  logic                 r_rd_oor_p1;

  logic                 w_accept;
  logic                 w_swap;
  logic                 w_we;
  logic [SB_ADDR_W:0]   w_waddr;
  logic [1:0]           w_wdata;
  logic                 w_rd_inr;
  logic                 w_re;
  logic [SB_ADDR_W:0]   w_raddr;
  logic [1:0]           w_ram_q;

  assign w_accept = (r_state == SB_IDLE) || (r_state == SB_WAIT_FRAME);
  assign w_swap   = ((r_state == SB_IDLE) && swapBuffer && frame_start) ||
                    ((r_state == SB_WAIT_FRAME) && frame_start);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = {~r_front_sel, pix_addr(x_in, y_in)};
    w_wdata = color_in;
    if (r_state == SB_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = {~r_front_sel, r_clr_cnt};
      w_wdata = CLEAR_COLOR;
    end else if (w_accept && draw && in_range(x_in, y_in)) begin
      w_we = 1'b1;
    end
  end

  // Out-of-range reads skip the RAM and are forced to zero on the output side.
  assign w_rd_inr = in_range(rd_x, rd_y);
  assign w_re     = rd_en && w_rd_inr;
  assign w_raddr  = {r_front_sel, pix_addr(rd_x, rd_y)};

  screen_buffer_ram #(
    .PIXELS (PIXELS),
    .AW     (SB_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SB_IDLE;
      r_front_sel <= 1'b0;
      r_clr_cnt   <= '0;
    end else begin
      case (r_state)
        SB_IDLE, SB_WAIT_FRAME: begin
          if (w_swap) begin
            r_front_sel <= ~r_front_sel;
            r_clr_cnt   <= '0;
            r_state     <= CLEAR_ON_SWAP ? SB_CLEAR : SB_ACK;
          end else if (swapBuffer) begin
            r_state <= SB_WAIT_FRAME;
          end
        end
        SB_CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_clr_cnt <= '0;
            r_state   <= SB_ACK;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        SB_ACK:  r_state <= SB_IDLE;
        default: r_state <= SB_IDLE;
      endcase
    end
  end

  // Read pipeline stage p1: qualifiers aligned with the registered RAM output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_vld_p1 <= 1'b0;
      r_rd_oor_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= rd_en;
      r_rd_oor_p1 <= rd_en && !w_rd_inr;
    end
  end

  assign rd_valid      = r_rd_vld_p1;
  assign rd_color      = (r_rd_vld_p1 && !r_rd_oor_p1) ? w_ram_q : 2'b00;
  assign front_sel     = r_front_sel;
  assign clearing      = (r_state == SB_CLEAR);
  assign bufferSwapped = (r_state == SB_ACK);

endmodule

// File: tb/tb_screen_buffer.sv
// Directed bench for screen_buffer: table-driven writes/reads plus swap, frame-wait and reset sequences.
module tb_screen_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [1:0] color_in;
  logic       swapBuffer;
  logic       bufferSwapped;
  logic       frame_start;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic [1:0] rd_color;
  logic       rd_valid;
  logic       front_sel;
  logic       clearing;

  always #5 clk = ~clk;

  screen_buffer #(
    .WIDTH         (160),
    .HEIGHT        (144),
    .CLEAR_ON_SWAP (1'b1),
    .CLEAR_COLOR   (2'b00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .draw          (draw),
    .x_in          (x_in),
    .y_in          (y_in),
    .color_in      (color_in),
    .swapBuffer    (swapBuffer),
    .bufferSwapped (bufferSwapped),
    .frame_start   (frame_start),
    .rd_en         (rd_en),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_color      (rd_color),
    .rd_valid      (rd_valid),
    .front_sel     (front_sel),
    .clearing      (clearing)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] c;
  } wr_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] exp;
  } rd_t;

  wr_t wv [10];
  rd_t rv [13];

  int n_cmp = 0;
  int n_bad = 0;

  localparam int CLEAR_CYCLES = 160 * 144;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] x, input logic [7:0] y, input logic [1:0] c);
    draw     = 1'b1;
    x_in     = x;
    y_in     = y;
    color_in = c;
    step();
    draw = 1'b0;
  endtask

  task automatic run_reads(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      rd_en = 1'b1;
      rd_x  = rv[i].x;
      rd_y  = rv[i].y;
      step();
      chk($sformatf("%s_valid(%0d,%0d)", tag, rv[i].x, rv[i].y), int'(rd_valid), 1);
      chk($sformatf("%s_color(%0d,%0d)", tag, rv[i].x, rv[i].y), int'(rd_color), int'(rv[i].exp));
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_valid_after_idle"}, int'(rd_valid), 0);
    chk({tag, "_color_after_idle"}, int'(rd_color), 0);
  endtask

  // Drives the swap at cycle T, then tracks cycles T+1.. until the acknowledge.
  task automatic do_swap(input bit scribble, output int ack_cyc, output int bad_clear);
    swapBuffer  = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    if (scribble) begin
      draw     = 1'b1;
      x_in     = 8'd0;
      y_in     = 8'd0;
      color_in = 2'd3;
    end
    ack_cyc   = -1;
    bad_clear = 0;
    for (int cyc = 1; cyc <= 30000; cyc++) begin
      if (clearing != (cyc <= CLEAR_CYCLES))
        bad_clear++;
      if (bufferSwapped) begin
        ack_cyc = cyc;
        break;
      end
      step();
    end
    swapBuffer = 1'b0;
    draw       = 1'b0;
  endtask

  initial begin
    int ack;
    int bad;

    reset       = 1'b0;
    draw        = 1'b0;
    x_in        = '0;
    y_in        = '0;
    color_in    = '0;
    swapBuffer  = 1'b0;
    frame_start = 1'b0;
    rd_en       = 1'b0;
    rd_x        = '0;
    rd_y        = '0;

    wv[0] = '{8'd5,   8'd7,   2'd3};
    wv[1] = '{8'd0,   8'd0,   2'd1};
    wv[2] = '{8'd0,   8'd1,   2'd1};
    wv[3] = '{8'd159, 8'd143, 2'd2};
    wv[4] = '{8'd40,  8'd11,  2'd3};
    wv[5] = '{8'd159, 8'd0,   2'd3};
    wv[6] = '{8'd0,   8'd143, 2'd2};
    wv[7] = '{8'd160, 8'd0,   2'd2};
    wv[8] = '{8'd0,   8'd144, 2'd2};
    wv[9] = '{8'd255, 8'd255, 2'd3};

    rv[0]  = '{8'd5,   8'd7,   2'd3};
    rv[1]  = '{8'd0,   8'd0,   2'd1};
    rv[2]  = '{8'd0,   8'd1,   2'd1};
    rv[3]  = '{8'd159, 8'd143, 2'd2};
    rv[4]  = '{8'd159, 8'd0,   2'd3};
    rv[5]  = '{8'd0,   8'd143, 2'd2};
    rv[6]  = '{8'd40,  8'd11,  2'd3};
    rv[7]  = '{8'd200, 8'd10,  2'd0};
    rv[8]  = '{8'd160, 8'd0,   2'd0};
    rv[9]  = '{8'd0,   8'd144, 2'd0};
    rv[10] = '{8'd0,   8'd0,   2'd0};
    rv[11] = '{8'd0,   8'd1,   2'd0};
    rv[12] = '{8'd159, 8'd143, 2'd0};

    repeat (3) step();
    chk("rst_front_sel", int'(front_sel), 0);
    chk("rst_bufferSwapped", int'(bufferSwapped), 0);
    chk("rst_clearing", int'(clearing), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_color", int'(rd_color), 0);
    reset = 1'b1;
    step();

    // Half the pattern in IDLE, the rest while parked in WAIT_FRAME.
    for (int i = 0; i < 5; i++) do_write(wv[i].x, wv[i].y, wv[i].c);
    swapBuffer = 1'b1;
    step();
    for (int i = 5; i < 10; i++) do_write(wv[i].x, wv[i].y, wv[i].c);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bufferSwapped || clearing || front_sel) bad++;
      step();
    end
    chk("wait_frame_quiet_cycles", bad, 0);

    do_swap(1'b1, ack, bad);
    chk("swap1_ack_cycle", ack, CLEAR_CYCLES + 1);
    chk("swap1_clearing_window_errors", bad, 0);
    chk("swap1_front_sel", int'(front_sel), 1);
    step();
    chk("swap1_ack_one_cycle", int'(bufferSwapped), 0);
    chk("swap1_clearing_after", int'(clearing), 0);

    do_write(8'd0, 8'd144, 2'd2);
    do_write(8'd160, 8'd0, 2'd2);
    run_reads(0, 9, "swap1");

    do_swap(1'b0, ack, bad);
    chk("swap2_ack_cycle", ack, CLEAR_CYCLES + 1);
    chk("swap2_front_sel", int'(front_sel), 0);
    step();
    run_reads(10, 12, "swap2");

    // Reset landing at T+100 of a clear.
    swapBuffer  = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (98) step();
    rd_en = 1'b1;
    rd_x  = 8'd0;
    rd_y  = 8'd0;
    step();
    rd_en = 1'b0;
    chk("midclr_clearing", int'(clearing), 1);
    chk("midclr_front_sel", int'(front_sel), 1);
    chk("midclr_rd_valid", int'(rd_valid), 1);
    reset      = 1'b0;
    swapBuffer = 1'b0;
    #1;
    chk("async_rst_front_sel", int'(front_sel), 0);
    chk("async_rst_clearing", int'(clearing), 0);
    chk("async_rst_bufferSwapped", int'(bufferSwapped), 0);
    chk("async_rst_rd_valid", int'(rd_valid), 0);
    chk("async_rst_rd_color", int'(rd_color), 0);
    step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (bufferSwapped || clearing || front_sel) bad++;
      step();
    end
    chk("post_reset_idle_cycles", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
